// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited requests and a {pc, instr} buffer for decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    output logic        pc_stall_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        flush_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [CW-1:0] out_cnt, disc_cnt, occ;
    logic [AW-1:0] tag_wr, tag_rd, wr, rd;
    logic [31:0]   tag_mem [DEPTH];
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic          acc, rv, keep, pop;
    // credits count both in-flight and buffered entries, so a same-cycle pop never frees one
    assign imem_req_o  = !reset_i && !flush_i && ({1'b0, out_cnt} + {1'b0, occ} < (CW+1)'(DEPTH));
    assign imem_addr_o = {pc_i[31:2], 2'b00};
    assign acc         = imem_req_o && imem_gnt_i;
    assign pc_stall_o  = reset_i || (!flush_i && !acc);
    assign rv          = imem_rvalid_i && out_cnt != '0;
    assign keep        = rv && disc_cnt == '0 && !flush_i;
    assign id_valid_o  = occ != '0;
    assign pop         = id_valid_o && id_ready_i;
    assign id_instr_o  = id_valid_o ? ins_mem[rd] : 32'h00000013;
    assign id_pc_o     = id_valid_o ? pc_mem[rd] : RESET_PC;
    always_ff @(posedge clk) begin
        if (reset_i) begin
            out_cnt  <= '0;
            disc_cnt <= '0;
            occ      <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            wr       <= '0;
            rd       <= '0;
        end else if (flush_i) begin
            out_cnt  <= out_cnt - CW'(rv);
            disc_cnt <= out_cnt - CW'(rv);
            occ      <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            wr       <= '0;
            rd       <= '0;
        end else begin
            out_cnt <= out_cnt + CW'(acc) - CW'(rv);
            occ     <= occ + CW'(keep) - CW'(pop);
            rd      <= rd + AW'(pop);
            if (rv && disc_cnt != '0) disc_cnt <= disc_cnt - CW'(1);
            if (acc) begin
                tag_mem[tag_wr] <= pc_i;
                tag_wr          <= tag_wr + AW'(1);
            end
            if (keep) begin
                pc_mem[wr]  <= tag_mem[tag_rd];
                ins_mem[wr] <= imem_rdata_i;
                wr          <= wr + AW'(1);
                tag_rd      <= tag_rd + AW'(1);
            end
        end
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register and its PC+4 / PC+imm adders.
- Takes the current PC, issues in-order requests to instruction memory over a req/gnt/rvalid interface, and buffers returned instructions with their PCs in a small FIFO.
- Presents buffered instructions to decode over a valid/ready handshake.
- Drives the PC register's hold input so the PC advances only when a fetch request is accepted or on a redirect.

Parameters:
- RESET_PC, 32'h80000000, PC value presented on id_pc_o while empty/after reset.
- DEPTH, 2, instruction FIFO entries; also the cap on outstanding requests plus buffered entries (power of 2, >=2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_i  in  1  synchronous reset, active-high.
- pc_i  in  32  current PC from the PC register.
- pc_stall_o  out  1  to PC register en; 1 = hold PC, 0 = load pc_next.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  word-aligned fetch address, {pc_i[31:2],2'b00}.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid (in order, >=1 cycle after gnt).
- imem_rdata_i  in  32  instruction word.
- flush_i  in  1  redirect: discard everything in flight and buffered.
- id_valid_o  out  1  instruction available to decode.
- id_ready_i  in  1  decode accepts.
- id_instr_o  out  32  FIFO head instruction.
- id_pc_o  out  32  PC of FIFO head instruction.

Behaviour:
- State: outstanding count (0..DEPTH), discard count (0..DEPTH), PC-tag FIFO for in-flight requests (DEPTH entries), instruction FIFO of {pc, instr} (DEPTH entries).
- Issue: imem_req_o = !reset_i && !flush_i && (outstanding + occupancy < DEPTH). A pop in the same cycle does not free a credit.
- Accept (req && gnt): push pc_i to tag FIFO; outstanding +1.
- pc_stall_o = 0 when flush_i; else !(imem_req_o && imem_gnt_i); 1 during reset.
- Response (rvalid): outstanding -1.
  - If discard count > 0: decrement discard count; drop data.
  - Else: push {tag FIFO head, imem_rdata_i} into instruction FIFO; pop tag.
  - Overflow is impossible by the credit rule. rvalid with outstanding = 0 is a protocol error; ignore it and keep counters unchanged.
- Latency: rvalid in cycle N gives id_valid_o = 1 in cycle N+1. No combinational rdata-to-decode bypass.
- Decode handshake: pop on id_valid_o && id_ready_i. id_instr_o / id_pc_o hold stable while valid && !ready. Push and pop in the same cycle are allowed at any occupancy.
- Empty: id_valid_o = 0, id_instr_o = 32'h00000013 (NOP), id_pc_o = RESET_PC.
- Flush (registered effect at edge):
  - Clear instruction FIFO and tag FIFO.
  - Discard count := outstanding − (1 if rvalid this cycle).
  - An rvalid in the flush cycle is dropped.
  - No request in the flush cycle.
  - Next cycle id_valid_o = 0.
- Reset (any time, including mid-transaction):
  - All counters and FIFOs cleared; imem_req_o = 0, id_valid_o = 0, id_instr_o = NOP, id_pc_o = RESET_PC, pc_stall_o = 1.
  - Responses to requests issued before reset are the memory's responsibility to cancel; none are expected.
- Pointers wrap modulo DEPTH. Count widths are clog2(DEPTH)+1.

Test Plan:
- Reset: assert reset_i 2 cycles -> imem_req_o=0, id_valid_o=0, id_pc_o=32'h80000000, id_instr_o=32'h00000013, pc_stall_o=1.
- Streaming: gnt=1 always, rvalid one cycle after gnt, id_ready_i=1, pc_i 80000000/04/08… -> decode sees instrs in order with matching PCs; pc_stall_o=0 on each accepted cycle.
- Backpressure: id_ready_i=0 after first response -> FIFO fills to 2, imem_req_o drops to 0, pc_stall_o=1, head stays {80000000, instr0}. Release ready -> drains in order, no loss or duplicate.
- Grant stall: imem_gnt_i=0 for 3 cycles -> imem_req_o held high, imem_addr_o stable at pc_i, pc_stall_o=1 throughout.
- Flush with 2 outstanding: flush_i pulse, then two rvalids -> both dropped, id_valid_o stays 0. Next fetch from redirected pc_i (e.g. 80000100) delivered with id_pc_o=80000100.
- Flush coincident with rvalid, and reset_i mid-stream with 1 outstanding -> rvalid data never reaches decode; all outputs return to reset values the cycle after reset.
